// File: rtl/product_accumulator.sv
// product_accumulator
// Sums a programmed number of signed multiplier products into a guard-banded
// accumulator. It returns the sum on a valid/ready result handshake.
// prod_ready, acc_valid and busy are decoded from the state register only,
// so no input reaches an output combinationally.

module product_accumulator #(
    parameter int PROD_W = 64,
    parameter int CNT_W  = 8,
    parameter int ACC_W  = PROD_W + CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  len,
    input  logic              flush,
    input  logic [PROD_W-1:0] product,
    input  logic              prod_valid,
    output logic              prod_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              acc_valid,
    input  logic              acc_ready,
    output logic [CNT_W-1:0]  acc_count,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q,     state_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic [ACC_W-1:0]   acc_q,       acc_d;
    logic [CNT_W-1:0]   count_q,     count_d;
    logic [ACC_W-1:0]   product_ext;
    logic               beat;

    // The guard bits above the product take copies of its sign bit.
    // This keeps the full-width add a correct two's-complement sum.
    assign product_ext = {{(ACC_W-PROD_W){product[PROD_W-1]}}, product};

    // A beat counts only in ACCUM. Flush overrides it, so a product that is
    // presented during a flush cycle is dropped and never added.
    assign beat = (state_q == ACCUM) && prod_valid && !flush;

    // Next-state logic and datapath updates. Flush has priority over the
    // normal state machine. In IDLE, start is the only thing that can change
    // state; it is ignored everywhere else.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        acc_d       = acc_q;
        count_d     = count_q;

        if (flush) begin
            state_d     = IDLE;
            remaining_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        remaining_d = len;
                        acc_d       = '0;
                        count_d     = '0;
                        if (len == '0) begin
                            state_d = DONE;
                        end else begin
                            state_d = ACCUM;
                        end
                    end
                end

                ACCUM: begin
                    if (beat) begin
                        acc_d       = acc_q + product_ext;
                        count_d     = count_q + CNT_W'(1);
                        remaining_d = remaining_q - CNT_W'(1);
                        if (remaining_q == CNT_W'(1)) begin
                            state_d = DONE;
                        end
                    end
                end

                DONE: begin
                    if (acc_ready) begin
                        state_d = IDLE;
                    end
                end

                default: begin
                    state_d     = IDLE;
                    remaining_d = '0;
                end
            endcase
        end
    end

    // State and datapath registers. The reset is synchronous and overrides
    // every other update.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            acc_q       <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
        end
    end

    assign prod_ready = (state_q == ACCUM);
    assign acc_valid  = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign acc_out    = acc_q;
    assign acc_count  = count_q;

endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator
// Drives product_accumulator with directed and randomized operations.
// Every result is compared with a reference sum that the bench builds with
// plain signed arithmetic.

module tb_product_accumulator;

    localparam int PROD_W = 64;
    localparam int CNT_W  = 8;
    localparam int ACC_W  = PROD_W + CNT_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [CNT_W-1:0]  len;
    logic              flush;
    logic [PROD_W-1:0] product;
    logic              prod_valid;
    logic              prod_ready;
    logic [ACC_W-1:0]  acc_out;
    logic              acc_valid;
    logic              acc_ready;
    logic [CNT_W-1:0]  acc_count;
    logic              busy;

    int n_cmp  = 0;
    int n_fail = 0;

    product_accumulator #(
        .PROD_W (PROD_W),
        .CNT_W  (CNT_W),
        .ACC_W  (ACC_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len        (len),
        .flush      (flush),
        .product    (product),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .acc_out    (acc_out),
        .acc_valid  (acc_valid),
        .acc_ready  (acc_ready),
        .acc_count  (acc_count),
        .busy       (busy)
    );

    // Free-running clock with a 10-unit period.
    always #5 clk = ~clk;

    // Advance one cycle, then settle 1 unit past the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start      = 1'b0;
        len        = '0;
        flush      = 1'b0;
        product    = '0;
        prod_valid = 1'b0;
        acc_ready  = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Issue start for one cycle. Afterwards the DUT has sampled it.
    task automatic issue_start(input int n);
        start = 1'b1;
        len   = CNT_W'(n);
        tick();
        start = 1'b0;
        len   = '0;
    endtask

    // Idle for gap cycles, then present p until a handshake completes.
    // The wait is bounded.
    task automatic send_beat(input logic [PROD_W-1:0] p, input int gap);
        int waited;
        prod_valid = 1'b0;
        for (int g = 0; g < gap; g++) tick();
        prod_valid = 1'b1;
        product    = p;
        waited     = 0;
        while (!prod_ready && waited < 50) begin
            tick();
            waited++;
        end
        if (!prod_ready) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL beat_timeout: prod_ready got %b required 1 within 50 cycles", prod_ready);
        end
        tick();
        prod_valid = 1'b0;
        product    = '0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({acc_valid, prod_ready, busy} !== 3'b000) begin
            n_fail++;
            $display("[TB] FAIL reset_flags: got v/r/b=%b required 000", {acc_valid, prod_ready, busy});
        end
        n_cmp++;
        if (acc_out !== '0 || acc_count !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_data: got acc=%h cnt=%0d required 0/0", acc_out, acc_count);
        end
    endtask

    task automatic test_basic();
        logic [PROD_W-1:0]       prods [3];
        logic signed [ACC_W-1:0] model;
        prods[0] = -64'sd10;
        prods[1] = 64'd60;
        prods[2] = 64'd220;
        model = '0;
        foreach (prods[i]) model = model + ACC_W'($signed(prods[i]));
        issue_start(3);
        n_cmp++;
        if ({prod_ready, busy, acc_valid} !== 3'b110) begin
            n_fail++;
            $display("[TB] FAIL basic_start_latency: got r/b/v=%b required 110", {prod_ready, busy, acc_valid});
        end
        prod_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            product = prods[i];
            tick();
            if (i == 1) begin
                n_cmp++;
                if (acc_valid !== 1'b0) begin
                    n_fail++;
                    $display("[TB] FAIL basic_early_valid: got %b required 0", acc_valid);
                end
            end
        end
        prod_valid = 1'b0;
        n_cmp++;
        if (acc_valid !== 1'b1 || prod_ready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL basic_done_latency: got v/r=%b%b required 10", acc_valid, prod_ready);
        end
        n_cmp++;
        if (acc_out !== model || acc_count !== 8'd3) begin
            n_fail++;
            $display("[TB] FAIL basic_sum: got acc=%0d cnt=%0d required %0d/3", $signed(acc_out), acc_count, model);
        end
        acc_ready = 1'b1;
        tick();
        acc_ready = 1'b0;
        n_cmp++;
        if ({busy, acc_valid} !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL basic_return_idle: got b/v=%b required 00", {busy, acc_valid});
        end
    endtask

    task automatic test_guard_bits();
        issue_start(2);
        send_beat(64'h8000_0000_0000_0000, 0);
        send_beat(64'h8000_0000_0000_0000, 0);
        n_cmp++;
        if (acc_valid !== 1'b1 || acc_out !== 72'hFF_0000_0000_0000_0000 || acc_count !== 8'd2) begin
            n_fail++;
            $display("[TB] FAIL guard_sum: got v=%b acc=%h cnt=%0d required 1/ff0000000000000000/2", acc_valid, acc_out, acc_count);
        end
        acc_ready = 1'b1;
        tick();
        acc_ready = 1'b0;
    endtask

    task automatic test_len_zero();
        bit saw_ready;
        issue_start(0);
        saw_ready = prod_ready;
        n_cmp++;
        if (acc_valid !== 1'b1 || acc_out !== '0 || acc_count !== '0) begin
            n_fail++;
            $display("[TB] FAIL len0_result: got v=%b acc=%h cnt=%0d required 1/0/0", acc_valid, acc_out, acc_count);
        end
        tick();
        saw_ready = saw_ready | prod_ready;
        acc_ready = 1'b1;
        tick();
        saw_ready = saw_ready | prod_ready;
        acc_ready = 1'b0;
        tick();
        saw_ready = saw_ready | prod_ready;
        n_cmp++;
        if (saw_ready !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL len0_no_ready: got ready_seen=%b busy=%b required 0/0", saw_ready, busy);
        end
    endtask

    task automatic test_gaps_and_hold();
        logic signed [ACC_W-1:0] model;
        int bad;
        model = '0;
        issue_start(4);
        for (int i = 1; i <= 4; i++) begin
            send_beat(PROD_W'(i), int'($urandom_range(0, 3)));
            model = model + ACC_W'(i);
        end
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            if (acc_valid !== 1'b1 || acc_out !== model || acc_count !== 8'd4) bad++;
            start = (c == 2);
            len   = 8'd7;
            tick();
        end
        start = 1'b0;
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("[TB] FAIL hold_stable: got %0d unstable cycles required 0 (acc=%0d cnt=%0d)", bad, $signed(acc_out), acc_count);
        end
        n_cmp++;
        if (acc_valid !== 1'b1 || acc_out !== model) begin
            n_fail++;
            $display("[TB] FAIL hold_start_ignored: got v=%b acc=%0d required 1/%0d", acc_valid, $signed(acc_out), model);
        end
        acc_ready = 1'b1;
        start     = 1'b1;
        len       = 8'd5;
        tick();
        acc_ready = 1'b0;
        start     = 1'b0;
        n_cmp++;
        if ({busy, acc_valid, prod_ready} !== 3'b000) begin
            n_fail++;
            $display("[TB] FAIL handshake_idle: got b/v/r=%b required 000", {busy, acc_valid, prod_ready});
        end
        tick();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL handshake_start_ignored: got busy=%b required 0", busy);
        end
    endtask

    task automatic test_flush();
        int saw_valid;
        issue_start(4);
        send_beat(64'd100, 0);
        flush      = 1'b1;
        prod_valid = 1'b1;
        product    = 64'd5;
        tick();
        flush      = 1'b0;
        prod_valid = 1'b0;
        n_cmp++;
        if ({busy, acc_valid, prod_ready} !== 3'b000) begin
            n_fail++;
            $display("[TB] FAIL flush_idle: got b/v/r=%b required 000", {busy, acc_valid, prod_ready});
        end
        n_cmp++;
        if (acc_out !== 72'd100 || acc_count !== 8'd1) begin
            n_fail++;
            $display("[TB] FAIL flush_dropped_beat: got acc=%0d cnt=%0d required 100/1", $signed(acc_out), acc_count);
        end
        saw_valid = 0;
        for (int c = 0; c < 4; c++) begin
            if (acc_valid) saw_valid++;
            tick();
        end
        n_cmp++;
        if (saw_valid != 0) begin
            n_fail++;
            $display("[TB] FAIL flush_no_valid: got %0d valid cycles required 0", saw_valid);
        end
        issue_start(1);
        send_beat(-64'sd7, 1);
        n_cmp++;
        if (acc_valid !== 1'b1 || acc_out !== -72'sd7 || acc_count !== 8'd1) begin
            n_fail++;
            $display("[TB] FAIL flush_new_op: got v=%b acc=%0d cnt=%0d required 1/-7/1", acc_valid, $signed(acc_out), acc_count);
        end
        acc_ready = 1'b1;
        tick();
        acc_ready = 1'b0;
    endtask

    task automatic test_rst_mid();
        issue_start(5);
        send_beat(64'd11, 0);
        send_beat(64'd22, 0);
        rst        = 1'b1;
        prod_valid = 1'b1;
        product    = 64'd33;
        tick();
        rst        = 1'b0;
        prod_valid = 1'b0;
        n_cmp++;
        if ({busy, acc_valid, prod_ready} !== 3'b000 || acc_out !== '0 || acc_count !== '0) begin
            n_fail++;
            $display("[TB] FAIL rst_mid: got b/v/r=%b acc=%0d cnt=%0d required 000/0/0", {busy, acc_valid, prod_ready}, $signed(acc_out), acc_count);
        end
    endtask

    task automatic test_random();
        logic signed [ACC_W-1:0] model;
        logic [PROD_W-1:0]       p;
        int n;
        int bad;
        for (int op = 0; op < 12; op++) begin
            n = int'($urandom_range(1, 9));
            model = '0;
            issue_start(n);
            for (int i = 0; i < n; i++) begin
                p = {$urandom, $urandom};
                if ($urandom_range(0, 3) == 0) p = {1'b1, {(PROD_W-1){1'b0}}};
                model = model + ACC_W'($signed(p));
                send_beat(p, int'($urandom_range(0, 2)));
            end
            bad = 0;
            for (int c = int'($urandom_range(0, 3)); c > 0; c--) begin
                if (acc_out !== model || acc_valid !== 1'b1) bad++;
                tick();
            end
            n_cmp++;
            if (acc_valid !== 1'b1 || acc_out !== model || acc_count !== CNT_W'(n) || bad != 0) begin
                n_fail++;
                $display("[TB] FAIL random_op%0d: got v=%b acc=%h cnt=%0d unstable=%0d required 1/%h/%0d/0", op, acc_valid, acc_out, acc_count, bad, model, n);
            end
            acc_ready = 1'b1;
            tick();
            acc_ready = 1'b0;
        end
    endtask

    // Run all scenarios in sequence, then print the summary.
    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_basic();
        test_guard_bits();
        test_len_zero();
        test_gaps_and_hold();
        test_flush();
        test_rst_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
